parking_occupancy_monitor: RTL

- Parametrised successor to the lot-full pulse logic in ParkingSystem.
- Tracks lot occupancy internally from debounced enter/exit sensors, so it no longer depends on an external FSM state.
- Flags full, near-full and empty, and emits a stretched, retriggerable "lot full" pulse when a car is refused.
- Keeps a saturating count of refused entries, and sits between the gate sensors and the display/light drivers.

---
 rtl/parking_occupancy_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/parking_occupancy_monitor.sv
// Parking lot occupancy tracker: debounced gate sensors, full/near-full/empty flags, refusal pulse and counter.
// Latency: occupancy, reject_count and full_pulse update DEBOUNCE edges after the first sample of a new raw level.
// Backpressure: none; every accepted sensor edge is handled in the cycle it is detected.
module parking_occupancy_monitor #(
  parameter int CAPACITY  = 15,
  parameter int CNT_W     = 4,
  parameter int NEAR_FULL = 13,
  parameter int DEBOUNCE  = 2,
  parameter int PULSE_LEN = 4,
  parameter int REJ_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter_sensor,
  input  logic             exit_sensor,
  input  logic             clear,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             near_full,
  output logic             empty,
  output logic             full_pulse,
  output logic [REJ_W-1:0] reject_count,
  output logic             underflow_err
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int PT_W = $clog2(PULSE_LEN + 1);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [PT_W-1:0]  PT_LAST = PT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] NF_V    = CNT_W'(NEAR_FULL);

  // Bit 0 is the entry gate, bit 1 the exit gate.
  logic [1:0] raw;
  assign raw = {exit_sensor, enter_sensor};

  logic [1:0]           filt_q, filt_d;
  logic [1:0]           hist_q;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [REJ_W-1:0] rej_q, rej_d;
  logic             uf_q, uf_d;
  logic             pulse_q, pulse_d;
  logic [PT_W-1:0]  ptmr_q, ptmr_d;

  logic enter_evt, exit_evt, refuse;

  // Debounce: count consecutive samples that disagree with the filtered level,
  // and flip the filtered level on the sample that would bring the count to DEBOUNCE.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int s = 0; s < 2; s++) begin
      if (raw[s] != filt_q[s]) begin
        if (db_cnt_q[s] == DB_LAST) begin
          filt_d[s] = raw[s];
        end else begin
          db_cnt_d[s] = db_cnt_q[s] + 1'b1;
        end
      end
    end
  end

  // Single-cycle rising edges of the filtered sensors.
  assign enter_evt = filt_q[0] & ~hist_q[0];
  assign exit_evt  = filt_q[1] & ~hist_q[1];

  // Occupancy, refusal accounting and lot-full pulse timer.
  always_comb begin
    occ_d   = occ_q;
    rej_d   = rej_q;
    uf_d    = uf_q;
    pulse_d = pulse_q;
    ptmr_d  = ptmr_q;
    refuse  = 1'b0;
    if (clear) begin
      occ_d   = '0;
      rej_d   = '0;
      uf_d    = 1'b0;
      pulse_d = 1'b0;
      ptmr_d  = '0;
    end else begin
      if (enter_evt && !exit_evt) begin
        if (occ_q < CAP_V) begin
          occ_d = occ_q + 1'b1;
        end else if (!filt_q[1]) begin
          // Lot full and nobody is on the exit sensor: the car is turned away.
          refuse = 1'b1;
        end
      end else if (exit_evt && !enter_evt) begin
        if (occ_q != '0) begin
          occ_d = occ_q - 1'b1;
        end else begin
          uf_d = 1'b1;
        end
      end

      if (refuse) begin
        if (!(&rej_q)) begin
          rej_d = rej_q + 1'b1;
        end
        pulse_d = 1'b1;
        ptmr_d  = PT_LAST;
      end else if (ptmr_q != '0) begin
        ptmr_d = ptmr_q - 1'b1;
      end else begin
        pulse_d = 1'b0;
      end
    end
  end

  // State registers; reset aborts any pulse or debounce in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= '0;
      hist_q   <= '0;
      db_cnt_q <= '0;
      occ_q    <= '0;
      rej_q    <= '0;
      uf_q     <= 1'b0;
      pulse_q  <= 1'b0;
      ptmr_q   <= '0;
    end else begin
      filt_q   <= filt_d;
      hist_q   <= filt_q;
      db_cnt_q <= db_cnt_d;
      occ_q    <= occ_d;
      rej_q    <= rej_d;
      uf_q     <= uf_d;
      pulse_q  <= pulse_d;
      ptmr_q   <= ptmr_d;
    end
  end

  assign occupancy     = occ_q;
  assign full          = (occ_q == CAP_V);
  assign near_full     = (occ_q >= NF_V);
  assign empty         = (occ_q == '0);
  assign full_pulse    = pulse_q;
  assign reject_count  = rej_q;
  assign underflow_err = uf_q;

endmodule
